// File: rtl/week5_pkg.sv
// Shared constants and types for the four-requester round-robin arbiter.
package week5_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0]   req_idx_t;

endpackage : week5_pkg

// File: rtl/week5_rr_arbiter4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface week5_rr_arbiter4_if;
  import week5_pkg::*;

  req_vec_t req;
  logic     done;
  req_vec_t gnt;
  req_idx_t gnt_idx;
  logic     gnt_valid;
  logic     timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );

endinterface : week5_rr_arbiter4_if

// File: rtl/onehot4_to_idx.sv
// Combinational 4-to-2 encoder; an all-zero (or malformed) vector encodes to 0.
module onehot4_to_idx
  import week5_pkg::*;
(
  input  req_vec_t onehot_i,
  output req_idx_t idx_o
);

  always_comb begin
    idx_o = '0;
    unique case (onehot_i)
      4'b0010: idx_o = 2'd1;
      4'b0100: idx_o = 2'd2;
      4'b1000: idx_o = 2'd3;
      default: idx_o = 2'd0;
    endcase
  end

endmodule : onehot4_to_idx

// File: rtl/week5_rr_arbiter4.sv
// Four-requester round-robin arbiter with done/drop/timeout release and
// same-edge handoff to the next requester in rotating priority order.
module week5_rr_arbiter4
  import week5_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic                 clk,
  input logic                 rst,
  week5_rr_arbiter4_if.slave  bus
);

  localparam int unsigned CntW = $clog2(MAX_HOLD);
  localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);

  logic            state_q, state_d;
  req_idx_t        ptr_q, ptr_d;
  req_idx_t        owner_q, owner_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  req_vec_t        gnt_q, gnt_d;
  req_idx_t        gnt_idx_q, gnt_idx_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic            timeout_q, timeout_d;

  logic     hold_hit;
  logic     rel_hit;
  req_idx_t ptr_sel;
  req_idx_t cand;
  logic     sel_found;
  req_idx_t sel_idx;
  req_vec_t sel_onehot;

  assign hold_hit = (hold_cnt_q == HoldLast);
  assign rel_hit  = (state_q == GRANT) &&
                    (bus.done || !bus.req[owner_q] || hold_hit);

  // On release the old owner drops to lowest priority before the rescan.
  assign ptr_sel = rel_hit ? owner_q + IDX_W'(1) : ptr_q;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr_sel + IDX_W'(k);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign sel_onehot = req_vec_t'(1) << sel_idx;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    timeout_d  = 1'b0;

    if (state_q == IDLE) begin
      gnt_d = '0;
      if (sel_found) begin
        state_d    = GRANT;
        owner_d    = sel_idx;
        gnt_d      = sel_onehot;
        hold_cnt_d = '0;
      end
    end else if (rel_hit) begin
      ptr_d      = ptr_sel;
      timeout_d  = hold_hit;
      hold_cnt_d = '0;
      if (sel_found) begin
        owner_d = sel_idx;
        gnt_d   = sel_onehot;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end else begin
      hold_cnt_d = hold_cnt_q + CntW'(1);
    end

    gnt_valid_d = |gnt_d;
  end

  onehot4_to_idx u_enc (
    .onehot_i (gnt_d),
    .idx_o    (gnt_idx_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule : week5_rr_arbiter4

// File: tb/tb_week5_rr_arbiter4.sv
// Directed bench: each step pushes the hand-computed post-edge outputs into a
// scoreboard queue tagged with the cycle they must appear in.
module tb_week5_rr_arbiter4;

  logic clk;
  logic rst;
  int unsigned cyc;
  int errors;
  int checks;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  gnt;
    logic        to;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  week5_rr_arbiter4_if bus ();

  week5_rr_arbiter4 #(
    .MAX_HOLD (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] exp_idx(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      logic [1:0] ei;
      logic       ev;
      e  = exp_q.pop_front();
      ei = exp_idx(e.gnt);
      ev = (e.gnt != 4'b0000);
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d reached monitor at cycle %0d",
                 e.name, e.cyc, cyc);
      end else if (bus.gnt !== e.gnt || bus.gnt_idx !== ei || bus.gnt_valid !== ev ||
                   bus.timeout !== e.to) begin
        errors++;
        $display("FAIL %s @%0d: got gnt=%b idx=%0d v=%b to=%b, want gnt=%b idx=%0d v=%b to=%b",
                 e.name, cyc, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout,
                 e.gnt, ei, ev, e.to);
      end
    end
  end

  // Apply inputs for the coming edge and record the outputs expected after it.
  task automatic step(input string name, input logic r, input logic [3:0] rq,
                      input logic d, input logic [3:0] eg, input logic et);
    exp_t e;
    rst      = r;
    bus.req  = rq;
    bus.done = d;
    e.cyc  = cyc + 1;
    e.gnt  = eg;
    e.to   = et;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    @(posedge clk);
    #1;

    step("reset", 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
    step("reset_hold", 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0);

    // Basic grant, then drop back to idle.
    step("basic_grant", 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
    step("basic_drop", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Round robin with done every third cycle.
    step("rr_reset", 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
    step("rr_g0", 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
    step("rr_g0", 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
    step("rr_g0", 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
    step("rr_g1", 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0);
    step("rr_g1", 1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0);
    step("rr_g1", 1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0);
    step("rr_g2", 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b0);
    step("rr_g2", 1'b0, 4'b1111, 1'b0, 4'b0100, 1'b0);
    step("rr_g2", 1'b0, 4'b1111, 1'b0, 4'b0100, 1'b0);
    step("rr_g3", 1'b0, 4'b1111, 1'b1, 4'b1000, 1'b0);
    step("rr_g3", 1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0);
    step("rr_g3", 1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0);
    step("rr_g0_wrap", 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0);
    step("rr_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Timeout hands off to requester 1 after eight cycles of requester 0.
    step("to_reset", 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) step("to_hold0", 1'b0, 4'b0011, 1'b0, 4'b0001, 1'b0);
    step("to_pulse", 1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1);
    step("to_after", 1'b0, 4'b0011, 1'b0, 4'b0010, 1'b0);
    step("to_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Sole requester is re-granted through its own timeout.
    for (int i = 0; i < 8; i++) step("sole_hold", 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0);
    step("sole_regrant", 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1);
    step("sole_after", 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0);
    step("sole_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Owner 1 keeps the grant while requester 3 toggles; owner drop hands to 3.
    step("own1_grant", 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0);
    step("nonown_up", 1'b0, 4'b1010, 1'b0, 4'b0010, 1'b0);
    step("nonown_down", 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0);
    step("nonown_up2", 1'b0, 4'b1010, 1'b0, 4'b0010, 1'b0);
    step("own_drop", 1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0);
    step("own3_hold", 1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0);

    // Reset mid-grant clears outputs; priority restarts at requester 0.
    step("pre_rst_g2", 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
    step("mid_rst", 1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0);
    step("post_rst", 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);

    // Reset on the would-be timeout edge must not pulse timeout.
    for (int i = 0; i < 7; i++) step("pre_to_hold", 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
    step("rst_at_to", 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);
    step("rst_at_to_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_week5_rr_arbiter4

// File: doc/week5_rr_arbiter4.md
# week5_rr_arbiter4

Four-requester round-robin arbiter that shares a single downstream resource (for example the 4-to-2 encoder datapath and its consumer) between four independent requesters. The block grants one requester at a time and produces a one-hot grant plus its 2-bit encoded index. Each grant is held until the owner signals completion, withdraws its request, or exceeds a bounded hold time. Priority rotates after every grant so that no requester starves.

## Interface
- `MAX_HOLD`, default 8: maximum cycles a single grant may last, legal range 2..16. Also sets the width of the hold counter, `$clog2(MAX_HOLD)`.

- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req`  in  4  — request lines; `req[i]` high means requester i wants the resource.
- `done`  in  1  — current owner finished; sampled only in GRANT.
- `gnt`  out  4  — registered one-hot grant; all zero when idle.
- `gnt_idx`  out  2  — registered binary index of the set bit of `gnt`; 0 when `gnt` is 0.
- `gnt_valid`  out  1  — high exactly when `gnt` is non-zero.
- `timeout`  out  1  — one-cycle pulse when a grant is revoked because it hit `MAX_HOLD`.

## Operation
- State machine has two states, IDLE and GRANT. Internal registers:
  - `ptr[1:0]`: the requester with highest priority.
  - `owner[1:0]`
  - `hold_cnt`
- **Selection:** the first i with `req[i]=1`, scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
- **IDLE:**
  - If `req` is non-zero, go to GRANT: `owner` = selected i, `gnt` = 1<<i, `gnt_idx` = i, `gnt_valid` = 1, `hold_cnt` = 0.
  - If `req` is zero, stay in IDLE with all outputs 0.
- **GRANT:** the grant is released when any of the following holds:
  - `done` = 1
  - `req[owner]` = 0
  - `hold_cnt` = `MAX_HOLD`-1, which also asserts `timeout` for the next cycle.
- **Otherwise in GRANT:** `hold_cnt` increments and the grant is held.
- **On release:**
  - Set `ptr` = `owner`+1 (mod 4), so the old owner becomes lowest priority.
  - Selection is done immediately with this new `ptr` on the current `req`.
  - If a requester is found, grant it on the same edge (back-to-back handoff, no idle cycle) and reset `hold_cnt` to 0.
  - If none is found, go to IDLE and clear the outputs.
  - The old owner can be re-granted only if it is the sole requester.
- **Simultaneous release conditions:** `done`, request drop and timeout in the same cycle count as one release. `timeout` pulses only if `hold_cnt` was at `MAX_HOLD`-1.
- **Request drop by non-owners:** ignored during GRANT.
- **Reset values:**
  - State IDLE.
  - `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0.
  - `ptr`=0, so requester 0 has first priority.
  - `owner`=0, `hold_cnt`=0.
- **Reset mid-grant:** the grant is dropped at that edge, with no handoff and no timeout pulse.

## Timing
- Grant latency: `req` sampled at edge n gives `gnt` visible after edge n, i.e. 1 cycle.
- Release latency:
  - Release conditions sampled at edge n change `gnt` after edge n.
  - The next owner is visible in the same cycle the old grant drops.
- Maximum grant length is `MAX_HOLD` cycles.
- Worst-case wait for a continuously requesting input is 3×`MAX_HOLD` cycles plus 1.
- `gnt`, `gnt_idx`, `gnt_valid` and `timeout` are all registered; there is no combinational path from inputs to outputs.
- `timeout` is high for exactly one cycle, the first cycle of the following grant or idle period.

## Structure
- Shared package `week5_pkg`:
  - state encoding `IDLE`=1'b0, `GRANT`=1'b1
  - `NUM_REQ`=4
  - `IDX_W`=2
- One sub-module, `onehot4_to_idx`: a combinational 4-to-2 encoder producing `gnt_idx` from the next-state one-hot grant before registering.
- Rotating priority select is an `always` block inside the top module.

## Test plan
- **Basic grant:** reset, then `req`=4'b0100 → after one edge `gnt`=4'b0100, `gnt_idx`=2'b10, `gnt_valid`=1.
- **Round-robin:** `req`=4'b1111 held, `done` pulsed every 3 cycles → grants are 0,1,2,3,0 in order; `gnt_idx` = 00,01,10,11,00.
- **Timeout:** `MAX_HOLD`=8, `req`=4'b0011 held, `done`=0 → owner 0 for 8 cycles, then `timeout`=1 for one cycle and `gnt`=4'b0010.
- **Sole requester re-grant / idle:**
  - `req`=4'b0001 held through a timeout → `gnt` stays 4'b0001 with `timeout` pulse.
  - Then `req`=0 → IDLE with `gnt`=0 and `gnt_idx`=0.
- **Owner drop and non-owner drop:** owner 1, `req[3]` toggled → no effect; then `req`=4'b1000 → `gnt`=4'b1000 the next cycle.
- **Reset mid-grant:** `rst`=1 while `gnt`=4'b0100 → all outputs 0 after the edge; afterwards `req`=4'b1111 → `gnt`=4'b0001.
